// File: rtl/fetch_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit_if
//  Description : Bus bundle between the fetch stage, its instruction memory,
//                the hazard/branch control and the decoder.
//  Revision    : 1.0 - initial release
// ============================================================================
interface fetch_unit_if #(
  parameter int ADDR_W = 10
);
  logic              stall;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_addr;
  logic [ADDR_W-1:0] imem_addr;
  logic [17:0]       imem_data;
  logic [17:0]       inst;
  logic [ADDR_W-1:0] inst_pc;
  logic              inst_valid;
  logic              mem_second;

  // Fetch stage side
  modport master (
    input  stall, redirect_valid, redirect_addr, imem_data,
    output imem_addr, inst, inst_pc, inst_valid, mem_second
  );

  // Environment side (control, memory, decoder)
  modport slave (
    output stall, redirect_valid, redirect_addr, imem_data,
    input  imem_addr, inst, inst_pc, inst_valid, mem_second
  );
endinterface
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit
//  Description : Instruction fetch stage. Owns the PC, drives a synchronous
//                read instruction memory, presents one registered instruction
//                per cycle, repeats LOAD/STOR for their second cycle and
//                inserts NOP bubbles on stalls and redirects.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit #(
  parameter int              ADDR_W   = 10,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [17:0]     NOP_INST = 18'h00020
) (
  input  logic            clk,
  input  logic            reset,
  fetch_unit_if.master    bus
);

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  // Registered state
  state_t            r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_fetch_pc;
  logic              r_fetch_vld;
  logic [17:0]       r_inst;
  logic [ADDR_W-1:0] r_inst_pc;
  logic              r_inst_valid;
  logic              r_mem_second;

  // Next-state values
  state_t            w_nxt_state;
  logic [ADDR_W-1:0] w_nxt_pc;
  logic [ADDR_W-1:0] w_nxt_fetch_pc;
  logic              w_nxt_fetch_vld;
  logic [17:0]       w_nxt_inst;
  logic [ADDR_W-1:0] w_nxt_inst_pc;
  logic              w_nxt_inst_valid;
  logic              w_nxt_mem_second;
  logic [ADDR_W-1:0] w_imem_addr;
  logic              w_is_mem;

  // LOAD/STOR decode of the word arriving from memory (needs a second cycle)
  assign w_is_mem = (bus.imem_data[17:16] == 2'b00) &&
                    (bus.imem_data[15:12] == 4'b0100) &&
                    ((bus.imem_data[7:4] == 4'b0000) ||
                     (bus.imem_data[7:4] == 4'b0100));

  // State register; reset may land at any point, including mid-HOLD
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_RUN;
      r_pc         <= RESET_PC;
      r_fetch_pc   <= '0;
      r_fetch_vld  <= 1'b0;
      r_inst       <= NOP_INST;
      r_inst_pc    <= '0;
      r_inst_valid <= 1'b0;
      r_mem_second <= 1'b0;
    end else begin
      r_state      <= w_nxt_state;
      r_pc         <= w_nxt_pc;
      r_fetch_pc   <= w_nxt_fetch_pc;
      r_fetch_vld  <= w_nxt_fetch_vld;
      r_inst       <= w_nxt_inst;
      r_inst_pc    <= w_nxt_inst_pc;
      r_inst_valid <= w_nxt_inst_valid;
      r_mem_second <= w_nxt_mem_second;
    end
  end

  // Next-state and memory address: redirect beats HOLD beats stall beats run
  always_comb begin
    w_nxt_state      = r_state;
    w_nxt_pc         = r_pc;
    w_nxt_fetch_pc   = r_fetch_pc;
    w_nxt_fetch_vld  = r_fetch_vld;
    w_nxt_inst       = r_inst;
    w_nxt_inst_pc    = r_inst_pc;
    w_nxt_inst_valid = r_inst_valid;
    w_nxt_mem_second = r_mem_second;

    // While frozen, re-read the in-flight address so imem_data stays valid
    if (bus.redirect_valid) begin
      w_imem_addr = bus.redirect_addr;
    end else if (bus.stall || (r_state == ST_HOLD)) begin
      w_imem_addr = r_fetch_pc;
    end else begin
      w_imem_addr = r_pc;
    end

    if (bus.redirect_valid) begin
      // Target is fetched now; one bubble covers the memory latency.
      // Also squashes a LOAD/STOR capture on this edge, so no HOLD.
      w_nxt_pc         = bus.redirect_addr + 1'b1;
      w_nxt_fetch_pc   = bus.redirect_addr;
      w_nxt_fetch_vld  = 1'b1;
      w_nxt_inst       = NOP_INST;
      w_nxt_inst_valid = 1'b0;
      w_nxt_mem_second = 1'b0;
      w_nxt_state      = ST_RUN;
    end else begin
      case (r_state)
        ST_HOLD: begin
          // Repeat the same LOAD/STOR word, flagged as its second cycle
          w_nxt_inst_valid = 1'b1;
          w_nxt_mem_second = 1'b1;
          if (!bus.stall) begin
            w_nxt_state = ST_RUN;
          end
        end
        default: begin
          if (!bus.stall) begin
            w_nxt_pc         = r_pc + 1'b1;
            w_nxt_fetch_pc   = r_pc;
            w_nxt_fetch_vld  = 1'b1;
            w_nxt_mem_second = 1'b0;
            if (r_fetch_vld) begin
              w_nxt_inst       = bus.imem_data;
              w_nxt_inst_pc    = r_fetch_pc;
              w_nxt_inst_valid = 1'b1;
              if (w_is_mem) begin
                w_nxt_state = ST_HOLD;
              end
            end else begin
              w_nxt_inst       = NOP_INST;
              w_nxt_inst_valid = 1'b0;
            end
          end
        end
      endcase
    end
  end

  assign bus.imem_addr  = w_imem_addr;
  assign bus.inst       = r_inst;
  assign bus.inst_pc    = r_inst_pc;
  assign bus.inst_valid = r_inst_valid;
  assign bus.mem_second = r_mem_second;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_unit
//  Description : Self-checking bench for fetch_unit. Expected per-cycle
//                decoder-side outputs are queued with the stimulus and
//                popped after each rising edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

  localparam logic [17:0] c_nop  = 18'h00020;
  localparam logic [17:0] c_load = 18'h04003;

  logic clk;
  logic reset;

  fetch_unit_if #(.ADDR_W(10)) bus ();

  fetch_unit #(
    .ADDR_W   (10),
    .RESET_PC (10'h000),
    .NOP_INST (18'h00020)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [17:0] inst;
    logic [9:0]  pc;
    logic        valid;
    logic        ms;
    logic        chk_pc;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  int          n_checks;
  int          n_fail;
  logic [17:0] mem [0:1023];

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read instruction memory
  always @(posedge clk) bus.imem_data <= mem[bus.imem_addr];

  // Hard time limit so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  function automatic void push_exp(logic [17:0] i, logic [9:0] p, logic v, logic ms, logic cp);
    exp_t x;
    x.inst = i; x.pc = p; x.valid = v; x.ms = ms; x.chk_pc = cp;
    sb.push_back(x);
  endfunction

  task automatic init_mem();
    for (int i = 0; i < 1024; i++) mem[i] = 18'(i + 1);
  endtask

  // Hold reset across two edges, release 1 ns after an edge
  task automatic apply_reset();
    sb.delete();
    reset = 1'b1;
    bus.stall = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_addr = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.stall = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_addr = '0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (bus.inst !== c_nop || bus.inst_valid !== 1'b0 || bus.mem_second !== 1'b0 || bus.inst_pc !== 10'h000) begin
      n_fail++;
      $display("FAIL reset_outputs: got inst=%h pc=%h v=%b ms=%b, expected inst=%h pc=000 v=0 ms=0",
               bus.inst, bus.inst_pc, bus.inst_valid, bus.mem_second, c_nop);
    end
    n_checks++;
    if (bus.imem_addr !== 10'h000) begin
      n_fail++;
      $display("FAIL reset_imem_addr: got %h, expected 000", bus.imem_addr);
    end
    reset = 1'b0;
  endtask

  task automatic test_startup();
    apply_reset();
    push_exp(c_nop, 10'h000, 1'b0, 1'b0, 1'b1);
    push_exp(18'd1, 10'h000, 1'b1, 1'b0, 1'b1);
    push_exp(18'd2, 10'h001, 1'b1, 1'b0, 1'b1);
    push_exp(18'd3, 10'h002, 1'b1, 1'b0, 1'b1);
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      e = sb.pop_front();
      n_checks++;
      if (bus.inst !== e.inst || bus.inst_valid !== e.valid || bus.mem_second !== e.ms ||
          (e.chk_pc && bus.inst_pc !== e.pc)) begin
        n_fail++;
        $display("FAIL startup c%0d: got inst=%h pc=%h v=%b ms=%b, expected inst=%h pc=%h v=%b ms=%b",
                 c, bus.inst, bus.inst_pc, bus.inst_valid, bus.mem_second, e.inst, e.pc, e.valid, e.ms);
      end
    end
  endtask

  task automatic test_load();
    mem[3] = c_load;
    apply_reset();
    push_exp(c_nop,  10'h000, 1'b0, 1'b0, 1'b1);
    push_exp(18'd1,  10'h000, 1'b1, 1'b0, 1'b1);
    push_exp(18'd2,  10'h001, 1'b1, 1'b0, 1'b1);
    push_exp(18'd3,  10'h002, 1'b1, 1'b0, 1'b1);
    push_exp(c_load, 10'h003, 1'b1, 1'b0, 1'b1);
    push_exp(c_load, 10'h003, 1'b1, 1'b1, 1'b1);
    push_exp(18'd5,  10'h004, 1'b1, 1'b0, 1'b1);
    push_exp(18'd6,  10'h005, 1'b1, 1'b0, 1'b1);
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      e = sb.pop_front();
      n_checks++;
      if (bus.inst !== e.inst || bus.inst_valid !== e.valid || bus.mem_second !== e.ms ||
          (e.chk_pc && bus.inst_pc !== e.pc)) begin
        n_fail++;
        $display("FAIL load c%0d: got inst=%h pc=%h v=%b ms=%b, expected inst=%h pc=%h v=%b ms=%b",
                 c, bus.inst, bus.inst_pc, bus.inst_valid, bus.mem_second, e.inst, e.pc, e.valid, e.ms);
      end
    end
    mem[3] = 18'd4;
  endtask

  task automatic test_stall();
    apply_reset();
    push_exp(c_nop, 10'h000, 1'b0, 1'b0, 1'b1);
    push_exp(18'd1, 10'h000, 1'b1, 1'b0, 1'b1);
    push_exp(18'd2, 10'h001, 1'b1, 1'b0, 1'b1);
    push_exp(18'd3, 10'h002, 1'b1, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) push_exp(18'd3, 10'h002, 1'b1, 1'b0, 1'b1);
    push_exp(18'd4, 10'h003, 1'b1, 1'b0, 1'b1);
    push_exp(18'd5, 10'h004, 1'b1, 1'b0, 1'b1);
    for (int c = 0; c < 9; c++) begin
      bus.stall = (c >= 4 && c < 7);
      @(posedge clk); #1;
      e = sb.pop_front();
      n_checks++;
      if (bus.inst !== e.inst || bus.inst_valid !== e.valid || bus.mem_second !== e.ms ||
          (e.chk_pc && bus.inst_pc !== e.pc)) begin
        n_fail++;
        $display("FAIL stall c%0d: got inst=%h pc=%h v=%b ms=%b, expected inst=%h pc=%h v=%b ms=%b",
                 c, bus.inst, bus.inst_pc, bus.inst_valid, bus.mem_second, e.inst, e.pc, e.valid, e.ms);
      end
      if (bus.stall) begin
        n_checks++;
        if (bus.imem_addr !== 10'h003) begin
          n_fail++;
          $display("FAIL stall_imem_addr c%0d: got %h, expected 003", c, bus.imem_addr);
        end
      end
    end
    bus.stall = 1'b0;
  endtask

  task automatic test_redirect();
    apply_reset();
    push_exp(c_nop, 10'h000, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 6; k++) push_exp(18'(k + 1), 10'(k), 1'b1, 1'b0, 1'b1);
    push_exp(c_nop,     10'h000, 1'b0, 1'b0, 1'b0);
    push_exp(18'h00101, 10'h100, 1'b1, 1'b0, 1'b1);
    push_exp(18'h00102, 10'h101, 1'b1, 1'b0, 1'b1);
    for (int c = 0; c < 10; c++) begin
      bus.redirect_valid = (c == 7);
      bus.redirect_addr  = 10'h100;
      @(posedge clk); #1;
      e = sb.pop_front();
      n_checks++;
      if (bus.inst !== e.inst || bus.inst_valid !== e.valid || bus.mem_second !== e.ms ||
          (e.chk_pc && bus.inst_pc !== e.pc)) begin
        n_fail++;
        $display("FAIL redirect c%0d: got inst=%h pc=%h v=%b ms=%b, expected inst=%h pc=%h v=%b ms=%b",
                 c, bus.inst, bus.inst_pc, bus.inst_valid, bus.mem_second, e.inst, e.pc, e.valid, e.ms);
      end
    end
    bus.redirect_valid = 1'b0;
  endtask

  // Redirect while in HOLD, then redirect together with stall
  task automatic test_redirect_hold();
    mem[3] = c_load;
    apply_reset();
    push_exp(c_nop,     10'h000, 1'b0, 1'b0, 1'b1);
    push_exp(18'd1,     10'h000, 1'b1, 1'b0, 1'b1);
    push_exp(18'd2,     10'h001, 1'b1, 1'b0, 1'b1);
    push_exp(18'd3,     10'h002, 1'b1, 1'b0, 1'b1);
    push_exp(c_load,    10'h003, 1'b1, 1'b0, 1'b1);
    push_exp(c_nop,     10'h000, 1'b0, 1'b0, 1'b0);
    push_exp(18'h00201, 10'h200, 1'b1, 1'b0, 1'b1);
    push_exp(18'h00202, 10'h201, 1'b1, 1'b0, 1'b1);
    push_exp(c_nop,     10'h000, 1'b0, 1'b0, 1'b0);
    push_exp(18'h00011, 10'h010, 1'b1, 1'b0, 1'b1);
    push_exp(18'h00012, 10'h011, 1'b1, 1'b0, 1'b1);
    for (int c = 0; c < 11; c++) begin
      bus.redirect_valid = (c == 5) || (c == 8);
      bus.redirect_addr  = (c == 8) ? 10'h010 : 10'h200;
      bus.stall          = (c == 8);
      @(posedge clk); #1;
      e = sb.pop_front();
      n_checks++;
      if (bus.inst !== e.inst || bus.inst_valid !== e.valid || bus.mem_second !== e.ms ||
          (e.chk_pc && bus.inst_pc !== e.pc)) begin
        n_fail++;
        $display("FAIL redirect_hold c%0d: got inst=%h pc=%h v=%b ms=%b, expected inst=%h pc=%h v=%b ms=%b",
                 c, bus.inst, bus.inst_pc, bus.inst_valid, bus.mem_second, e.inst, e.pc, e.valid, e.ms);
      end
    end
    bus.redirect_valid = 1'b0;
    bus.stall = 1'b0;
    mem[3] = 18'd4;
  endtask

  // Redirect on the same edge that would capture a LOAD: no HOLD follows
  task automatic test_redirect_squash();
    mem[3] = c_load;
    apply_reset();
    push_exp(c_nop,     10'h000, 1'b0, 1'b0, 1'b1);
    push_exp(18'd1,     10'h000, 1'b1, 1'b0, 1'b1);
    push_exp(18'd2,     10'h001, 1'b1, 1'b0, 1'b1);
    push_exp(18'd3,     10'h002, 1'b1, 1'b0, 1'b1);
    push_exp(c_nop,     10'h000, 1'b0, 1'b0, 1'b0);
    push_exp(18'h00041, 10'h040, 1'b1, 1'b0, 1'b1);
    push_exp(18'h00042, 10'h041, 1'b1, 1'b0, 1'b1);
    for (int c = 0; c < 7; c++) begin
      bus.redirect_valid = (c == 4);
      bus.redirect_addr  = 10'h040;
      @(posedge clk); #1;
      e = sb.pop_front();
      n_checks++;
      if (bus.inst !== e.inst || bus.inst_valid !== e.valid || bus.mem_second !== e.ms ||
          (e.chk_pc && bus.inst_pc !== e.pc)) begin
        n_fail++;
        $display("FAIL squash c%0d: got inst=%h pc=%h v=%b ms=%b, expected inst=%h pc=%h v=%b ms=%b",
                 c, bus.inst, bus.inst_pc, bus.inst_valid, bus.mem_second, e.inst, e.pc, e.valid, e.ms);
      end
    end
    bus.redirect_valid = 1'b0;
    mem[3] = 18'd4;
  endtask

  // PC wraps from 3FF to 000
  task automatic test_wrap();
    apply_reset();
    push_exp(c_nop,     10'h000, 1'b0, 1'b0, 1'b0);
    push_exp(18'h00400, 10'h3FF, 1'b1, 1'b0, 1'b1);
    push_exp(18'd1,     10'h000, 1'b1, 1'b0, 1'b1);
    push_exp(18'd2,     10'h001, 1'b1, 1'b0, 1'b1);
    for (int c = 0; c < 4; c++) begin
      bus.redirect_valid = (c == 0);
      bus.redirect_addr  = 10'h3FF;
      @(posedge clk); #1;
      e = sb.pop_front();
      n_checks++;
      if (bus.inst !== e.inst || bus.inst_valid !== e.valid || bus.mem_second !== e.ms ||
          (e.chk_pc && bus.inst_pc !== e.pc)) begin
        n_fail++;
        $display("FAIL wrap c%0d: got inst=%h pc=%h v=%b ms=%b, expected inst=%h pc=%h v=%b ms=%b",
                 c, bus.inst, bus.inst_pc, bus.inst_valid, bus.mem_second, e.inst, e.pc, e.valid, e.ms);
      end
    end
    bus.redirect_valid = 1'b0;
  endtask

  // Reset asserted between edges while in HOLD takes effect at once
  task automatic test_async_reset();
    mem[3] = c_load;
    apply_reset();
    repeat (5) @(posedge clk);
    #1;
    n_checks++;
    if (bus.inst !== c_load || bus.inst_pc !== 10'h003 || bus.mem_second !== 1'b0) begin
      n_fail++;
      $display("FAIL async_pre: got inst=%h pc=%h ms=%b, expected inst=%h pc=003 ms=0",
               bus.inst, bus.inst_pc, bus.mem_second, c_load);
    end
    #1;
    reset = 1'b1;
    #1;
    n_checks++;
    if (bus.inst !== c_nop || bus.inst_pc !== 10'h000 || bus.inst_valid !== 1'b0 || bus.mem_second !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: got inst=%h pc=%h v=%b ms=%b, expected inst=%h pc=000 v=0 ms=0",
               bus.inst, bus.inst_pc, bus.inst_valid, bus.mem_second, c_nop);
    end
    n_checks++;
    if (bus.imem_addr !== 10'h000) begin
      n_fail++;
      $display("FAIL async_imem_addr: got %h, expected 000", bus.imem_addr);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    sb.delete();
    push_exp(c_nop, 10'h000, 1'b0, 1'b0, 1'b1);
    push_exp(18'd1, 10'h000, 1'b1, 1'b0, 1'b1);
    push_exp(18'd2, 10'h001, 1'b1, 1'b0, 1'b1);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      e = sb.pop_front();
      n_checks++;
      if (bus.inst !== e.inst || bus.inst_valid !== e.valid || bus.mem_second !== e.ms ||
          (e.chk_pc && bus.inst_pc !== e.pc)) begin
        n_fail++;
        $display("FAIL async_restart c%0d: got inst=%h pc=%h v=%b ms=%b, expected inst=%h pc=%h v=%b ms=%b",
                 c, bus.inst, bus.inst_pc, bus.inst_valid, bus.mem_second, e.inst, e.pc, e.valid, e.ms);
      end
    end
    mem[3] = 18'd4;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    bus.stall = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_addr = '0;
    init_mem();
    test_reset();
    test_startup();
    test_load();
    test_stall();
    test_redirect();
    test_redirect_hold();
    test_redirect_squash();
    test_wrap();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
